// File: rtl/bram_stream_engine.sv
// Port-B client for the 8-bit block RAM: LOAD streams bytes into consecutive addresses,
// DUMP reads consecutive addresses out through a 2-entry buffer that hides the read latency.
module bram_stream_engine #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DUMP = 2'd2, FIN = 2'd3} state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  rem_r;      // bytes still to accept (LOAD) or to issue (DUMP)
  logic [LEN_W-1:0]  rem_out_r;  // bytes still to hand out on the DUMP stream
  logic [DATA_W-1:0] fifo_r [2];
  logic              rd_ptr_r;
  logic              wr_ptr_r;
  logic [1:0]        occ_r;
  logic              inflight_r;

  logic              load_beat_s;
  logic              push_s;
  logic              pop_s;
  logic              issue_s;
  logic [1:0]        occ_sum_s;

  assign cmd_ready   = (state_r == IDLE);
  assign busy        = (state_r != IDLE);
  assign done        = (state_r == FIN);
  assign s_ready     = (state_r == LOAD);
  assign m_valid     = (state_r == DUMP) && (occ_r != 2'd0);
  assign m_data      = fifo_r[rd_ptr_r];
  assign ram_addr    = addr_r;
  assign ram_we      = load_beat_s;
  assign ram_din     = s_ready ? s_data : {DATA_W{1'b0}};
  assign load_beat_s = s_ready && s_valid;
  assign push_s      = inflight_r;
  assign pop_s       = m_valid && m_ready;

  // Read issue gate: a slot freed by this cycle's pop counts as free, keeping 1 byte/cycle.
  always_comb begin
    occ_sum_s = occ_r + {1'b0, inflight_r};
    issue_s   = 1'b0;
    if ((state_r == DUMP) && (rem_r != {LEN_W{1'b0}}) && ((occ_sum_s < 2'd2) || pop_s)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Command FSM, address/length counters and the DUMP output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      rem_r      <= {LEN_W{1'b0}};
      rem_out_r  <= {LEN_W{1'b0}};
      fifo_r[0]  <= {DATA_W{1'b0}};
      fifo_r[1]  <= {DATA_W{1'b0}};
      rd_ptr_r   <= 1'b0;
      wr_ptr_r   <= 1'b0;
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            addr_r    <= cmd_base;
            rem_r     <= cmd_len;
            rem_out_r <= cmd_len;
            if (cmd_len == {LEN_W{1'b0}}) begin
              state_r <= FIN;
            end else if (cmd_dir) begin
              state_r <= DUMP;
            end else begin
              state_r <= LOAD;
            end
          end
        end
        LOAD: begin
          if (load_beat_s) begin
            addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            rem_r  <= rem_r - {{(LEN_W-1){1'b0}}, 1'b1};
            if (rem_r == {{(LEN_W-1){1'b0}}, 1'b1}) begin
              state_r <= FIN;
            end
          end
        end
        DUMP: begin
          inflight_r <= issue_s;
          if (issue_s) begin
            addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            rem_r  <= rem_r - {{(LEN_W-1){1'b0}}, 1'b1};
          end
          if (push_s) begin
            fifo_r[wr_ptr_r] <= ram_dout;
            wr_ptr_r         <= ~wr_ptr_r;
          end
          if (pop_s) begin
            rd_ptr_r  <= ~rd_ptr_r;
            rem_out_r <= rem_out_r - {{(LEN_W-1){1'b0}}, 1'b1};
            if (rem_out_r == {{(LEN_W-1){1'b0}}, 1'b1}) begin
              state_r <= FIN;
            end
          end
          case ({push_s, pop_s})
            2'b10:   occ_r <= occ_r + 2'd1;
            2'b01:   occ_r <= occ_r - 2'd1;
            default: occ_r <= occ_r;
          endcase
        end
        FIN: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_engine.sv
// Directed bench for bram_stream_engine with a behavioural write-first RAM on port B.
module tb_bram_stream_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_dir;
  logic [10:0] cmd_base;
  logic [11:0] cmd_len;
  logic [7:0]  s_data;
  logic        s_valid, s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_ready;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;
  logic        busy, done;

  logic [7:0]  ram_mem [2048];
  logic [7:0]  exp_mem [2048];
  int          n_tests = 0;
  int          n_fail  = 0;

  bram_stream_engine dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Write-first synchronous RAM port
  always @(posedge clk) begin
    if (ram_we) begin
      ram_mem[ram_addr] <= ram_din;
      ram_dout          <= ram_din;
    end else begin
      ram_dout <= ram_mem[ram_addr];
    end
  end

  typedef struct {
    logic        dir;
    logic [10:0] base;
    logic [11:0] len;
    logic [7:0]  rdy;        // m_ready pattern, bit (cycle % 8)
    logic [7:0]  seed;       // LOAD byte i = seed + i*0x11
    int          exp_first;  // cycle of first m_valid after accept edge (-1: none)
    int          exp_done;   // cycle of done after accept edge
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input vec_t v, input string tag);
    int writes = 0, pops = 0, first = -1, done_cyc = -1;
    cmd_valid = 1'b1; cmd_dir = v.dir; cmd_base = v.base; cmd_len = v.len;
    #1;
    chk({tag, " cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    step;
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      s_valid = (!v.dir && writes < int'(v.len));
      s_data  = v.seed + 8'(writes * 17);
      m_ready = v.rdy[cyc % 8];
      #1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (ram_we) begin
        chk({tag, " wr_addr"}, {21'd0, ram_addr}, {21'd0, 11'(v.base + 11'(writes))});
        chk({tag, " wr_data"}, {24'd0, ram_din}, {24'd0, 8'(v.seed + 8'(writes * 17))});
        writes++;
      end
      if (m_valid && first < 0) first = cyc;
      if (m_valid && m_ready) begin
        chk({tag, " m_data"}, {24'd0, m_data}, {24'd0, exp_mem[11'(v.base + 11'(pops))]});
        pops++;
      end
      step;
    end
    s_valid = 1'b0;
    chk({tag, " done_cycle"}, done_cyc, v.exp_done);
    chk({tag, " writes"}, writes, v.dir ? 0 : int'(v.len));
    chk({tag, " pops"}, pops, v.dir ? int'(v.len) : 0);
    if (v.dir) chk({tag, " first_valid"}, first, v.exp_first);
    if (!v.dir) begin
      for (int i = 0; i < int'(v.len); i++) exp_mem[11'(v.base + 11'(i))] = v.seed + 8'(i * 17);
    end
    step;
    chk({tag, " idle"}, {30'd0, cmd_ready, done}, 32'd2);
  endtask

  vec_t vecs [9];
  vec_t tail;

  initial begin
    //          dir   base     len    rdy    seed  first done
    vecs[0] = '{1'b0, 11'h010, 12'd3, 8'hFF, 8'hA1, -1,  3};
    vecs[1] = '{1'b1, 11'h010, 12'd3, 8'hFF, 8'h00,  2,  5};
    vecs[2] = '{1'b0, 11'h100, 12'd8, 8'hFF, 8'h10, -1,  8};
    vecs[3] = '{1'b1, 11'h100, 12'd8, 8'h49, 8'h00,  2, 23};
    vecs[4] = '{1'b0, 11'h7FE, 12'd4, 8'hFF, 8'h5A, -1,  4};
    vecs[5] = '{1'b1, 11'h7FE, 12'd4, 8'hFF, 8'h00,  2,  6};
    vecs[6] = '{1'b0, 11'h300, 12'd0, 8'hFF, 8'h77, -1,  0};
    vecs[7] = '{1'b1, 11'h300, 12'd0, 8'hFF, 8'h00, -1,  0};
    vecs[8] = '{1'b0, 11'h200, 12'd5, 8'hFF, 8'h40, -1,  5};

    rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_base = 11'd0; cmd_len = 12'd0;
    s_data = 8'h77; s_valid = 1'b1; m_ready = 1'b1;
    step;
    step;
    chk("reset outputs", {24'd0, cmd_ready, s_ready, m_valid, ram_we, busy, done, 2'd0}, 32'h80);
    chk("reset ram_addr", {21'd0, ram_addr}, 32'd0);
    chk("reset ram_din", {24'd0, ram_din}, 32'd0);
    rst = 1'b0; s_valid = 1'b0;
    step;

    for (int i = 0; i < 9; i++) run_cmd(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a 5-byte LOAD after two bytes
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_base = 11'h200; cmd_len = 12'd5;
    step;
    cmd_valid = 1'b0; s_valid = 1'b1; s_data = 8'hD0;
    step;
    s_data = 8'hD1;
    step;
    s_valid = 1'b0; rst = 1'b1;
    step;
    rst = 1'b0;
    chk("midrst flags", {24'd0, cmd_ready, s_ready, m_valid, ram_we, busy, done, 2'd0}, 32'h80);
    chk("midrst ram_addr", {21'd0, ram_addr}, 32'd0);
    chk("midrst ram_din", {24'd0, ram_din}, 32'd0);
    exp_mem[11'h200] = 8'hD0;
    exp_mem[11'h201] = 8'hD1;
    step;
    tail = '{1'b1, 11'h200, 12'd5, 8'hFF, 8'h00, 2, 7};
    run_cmd(tail, "midrst dump");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
